// File: rtl/mem_access_stage_if.sv
// Data-memory bus between the MEM stage (master) and data memory (slave):
// valid/ready request handshake with byte-enabled writes and same-cycle read data.
interface mem_access_stage_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_wdata,
        output dmem_be,
        input  dmem_ready,
        input  dmem_rdata
    );

    modport slave (
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_wdata,
        input  dmem_be,
        output dmem_ready,
        output dmem_rdata
    );
endinterface

// File: rtl/mem_access_stage.sv
// Pipeline memory stage: data-memory handshake, load/store formatting and the MEM/WB register.
// Define MISALIGN_TRAP_EN to trap misaligned halfword/word accesses instead of ignoring low address bits.
module mem_access_stage #(
    parameter int WAIT_LIMIT = 255
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [31:0]               Alu_out_MEM,
    input  logic [31:0]               Mux2R2_in1_MEM,
    input  logic [2:0]                fund3_MEM,
    input  logic [4:0]                rsW_MEM,
    input  logic [31:0]               PCPlus4_MEM,
    input  logic [1:0]                WBSel_MEM,
    input  logic                      RegWEn_MEM,
    input  logic                      MemRW_MEM,
    mem_access_stage_if.master        dmem,
    output logic                      stall,
    output logic [31:0]               Result_WB,
    output logic [4:0]                rsW_WB,
    output logic                      RegWEn_WB,
    output logic                      bus_err,
    output logic                      misalign
);

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    localparam logic [7:0] LIMIT = 8'(WAIT_LIMIT);

    state_t      state;
    logic [7:0]  wait_count;

    logic [1:0]  lane;
    logic        is_store;
    logic        is_load;
    logic        store_fn_ok;
    logic        misaligned;
    logic        access;
    logic        wait_abort;
    logic [31:0] store_data;
    logic [3:0]  byte_en;
    logic [31:0] rdata_shifted;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_data;
    logic [31:0] wb_value;

    assign lane        = Alu_out_MEM[1:0];
    assign is_store    = MemRW_MEM;
    assign is_load     = !MemRW_MEM && (WBSel_MEM == 2'b00) && RegWEn_MEM;
    assign store_fn_ok = (fund3_MEM == 3'b000) || (fund3_MEM == 3'b001) || (fund3_MEM == 3'b010);

`ifdef MISALIGN_TRAP_EN
    logic half_access;
    logic word_access;

    assign half_access = ((fund3_MEM == 3'b001) && (is_load || is_store))
                       || ((fund3_MEM == 3'b101) && is_load);
    assign word_access = (fund3_MEM == 3'b010) && (is_load || is_store);
    assign misaligned  = (half_access && lane[0]) || (word_access && (lane != 2'b00));
`else
    assign misaligned  = 1'b0;
`endif

    assign access = !misaligned && (is_load || (is_store && store_fn_ok));

    // Upstream is frozen while in WAIT, so the request fields stay stable without extra holding registers.
    assign wait_abort      = (state == WAIT) && (wait_count >= LIMIT) && !dmem.dmem_ready;
    assign dmem.dmem_req   = !reset && access;
    assign dmem.dmem_we    = dmem.dmem_req && is_store;
    assign dmem.dmem_addr  = {Alu_out_MEM[31:2], 2'b00};
    assign dmem.dmem_wdata = is_store ? store_data : 32'd0;
    assign dmem.dmem_be    = byte_en;
    assign stall           = dmem.dmem_req && !dmem.dmem_ready && !wait_abort;

    always_comb begin
        store_data = Mux2R2_in1_MEM;
        byte_en    = 4'b1111;
        case (fund3_MEM[1:0])
            2'b00: begin
                store_data = {4{Mux2R2_in1_MEM[7:0]}};
                byte_en    = 4'b0001 << lane;
            end
            2'b01: begin
                store_data = {2{Mux2R2_in1_MEM[15:0]}};
                byte_en    = 4'b0011 << {lane[1], 1'b0};
            end
            default: begin
                store_data = Mux2R2_in1_MEM;
                byte_en    = 4'b1111;
            end
        endcase
    end

    // Byte lane comes from the full low address; halfword lane only from a[1].
    always_comb begin
        rdata_shifted = dmem.dmem_rdata >> {lane, 3'b000};
        load_byte     = rdata_shifted[7:0];
        load_half     = lane[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];
        case (fund3_MEM)
            3'b000:  load_data = {{24{load_byte[7]}}, load_byte};
            3'b001:  load_data = {{16{load_half[15]}}, load_half};
            3'b100:  load_data = {24'd0, load_byte};
            3'b101:  load_data = {16'd0, load_half};
            default: load_data = dmem.dmem_rdata;
        endcase
    end

    always_comb begin
        case (WBSel_MEM)
            2'b00:   wb_value = load_data;
            2'b10:   wb_value = PCPlus4_MEM;
            default: wb_value = Alu_out_MEM;
        endcase
    end

    // Stall cycles, aborts and misalign traps all write a bubble and keep the previous result.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            wait_count <= 8'd0;
            Result_WB  <= 32'd0;
            rsW_WB     <= 5'd0;
            RegWEn_WB  <= 1'b0;
            bus_err    <= 1'b0;
            misalign   <= 1'b0;
        end else begin
            bus_err  <= 1'b0;
            misalign <= 1'b0;
            case (state)
                IDLE: begin
                    if (access && !dmem.dmem_ready) begin
                        state      <= WAIT;
                        wait_count <= 8'd1;
                        RegWEn_WB  <= 1'b0;
                    end else if (misaligned) begin
                        misalign   <= 1'b1;
                        RegWEn_WB  <= 1'b0;
                    end else begin
                        Result_WB  <= wb_value;
                        rsW_WB     <= rsW_MEM;
                        RegWEn_WB  <= RegWEn_MEM && !is_store;
                    end
                end
                WAIT: begin
                    if (dmem.dmem_ready) begin
                        state      <= IDLE;
                        wait_count <= 8'd0;
                        Result_WB  <= wb_value;
                        rsW_WB     <= rsW_MEM;
                        RegWEn_WB  <= RegWEn_MEM && !is_store;
                    end else if (wait_abort) begin
                        state      <= IDLE;
                        wait_count <= 8'd0;
                        bus_err    <= 1'b1;
                        RegWEn_WB  <= 1'b0;
                    end else begin
                        wait_count <= wait_count + 8'd1;
                        RegWEn_WB  <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    wait_count <= 8'd0;
                end
            endcase
        end
    end

endmodule
